// File: rtl/alu_16bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_16bit                                                    |
// | Description : Single-cycle-latency ALU (ADD/OR/AND/SUB/XOR/SLL/SRL/SLT)    |
// |               with registered result and zero flag. Shifts are built only  |
// |               when the macro ALU16_SHIFT_EN is defined.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH-1:0] outPut,
  output logic             isZero
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SLL = 3'b101;
  localparam logic [2:0] c_OP_SRL = 3'b110;
  localparam logic [2:0] c_OP_SLT = 3'b111;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;

  logic [WIDTH-1:0] r_out;
  logic             r_zero;

  assign w_sum  = aIn + bIn;
  assign w_diff = aIn - bIn;
  assign w_lt   = $signed(aIn) < $signed(bIn);

`ifdef ALU16_SHIFT_EN
  localparam int c_SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] w_sll_stage [0:c_SHW];
  logic [WIDTH-1:0] w_srl_stage [0:c_SHW];

  assign w_sll_stage[0] = aIn;
  assign w_srl_stage[0] = aIn;

  // Log-depth barrel shifter: stage i shifts by 2**i when bIn[i] is set,
  // so only the low c_SHW bits of bIn ever influence the amount.
  for (genvar i = 0; i < c_SHW; i++) begin : g_shift_stage
    assign w_sll_stage[i+1] = bIn[i] ? (w_sll_stage[i] << (2 ** i)) : w_sll_stage[i];
    assign w_srl_stage[i+1] = bIn[i] ? (w_srl_stage[i] >> (2 ** i)) : w_srl_stage[i];
  end : g_shift_stage

  assign w_sll = w_sll_stage[c_SHW];
  assign w_srl = w_srl_stage[c_SHW];
`else
  assign w_sll = '0;
  assign w_srl = '0;
`endif

  always_comb begin
    w_result = '0;
    case (aluOp)
      c_OP_ADD: w_result = w_sum;
      c_OP_OR:  w_result = aIn | bIn;
      c_OP_AND: w_result = aIn & bIn;
      c_OP_SUB: w_result = w_diff;
      c_OP_XOR: w_result = aIn ^ bIn;
      c_OP_SLL: w_result = w_sll;
      c_OP_SRL: w_result = w_srl;
      c_OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
      default:  w_result = '0;
    endcase
  end

  // Flag is derived from the same combinational result so it can never
  // disagree with the registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= '0;
      r_zero <= 1'b1;
    end else begin
      r_out  <= w_result;
      r_zero <= (w_result == '0);
    end
  end

  assign outPut = r_out;
  assign isZero = r_zero;

endmodule : alu_16bit
`default_nettype wire

// File: tb/tb_alu_16bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_16bit                                                 |
// | Description : Scoreboard bench for alu_16bit: directed and random ops      |
// |               checked against an arithmetic reference model.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_16bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  aluOp = '0;
  logic [15:0] aIn = '0;
  logic [15:0] bIn = '0;
  logic [15:0] outPut;
  logic        isZero;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_16bit #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .aluOp  (aluOp),
    .aIn    (aIn),
    .bIn    (bIn),
    .outPut (outPut),
    .isZero (isZero)
  );

  function automatic logic [15:0] model(input int op, input int a, input int b);
    int r;
    int sa;
    int sb;
    r = 0;
    case (op)
      0: r = (a + b) % 65536;
      1: r = a | b;
      2: r = a & b;
      3: r = (a - b + 65536) % 65536;
      4: r = a ^ b;
`ifdef ALU16_SHIFT_EN
      5: r = (a * (1 << (b % 16))) % 65536;
      6: r = a / (1 << (b % 16));
`else
      5: r = 0;
      6: r = 0;
`endif
      7: begin
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r  = (sa < sb) ? 1 : 0;
      end
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic issue(input logic rst, input int op, input int a, input int b, input string tag);
    exp_t e;
    @(negedge clk);
    reset = rst;
    aluOp = op[2:0];
    aIn   = a[15:0];
    bIn   = b[15:0];
    e.res  = rst ? 16'h0000 : model(op, a, b);
    e.zero = (e.res == 16'h0000);
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Monitor: every edge registers exactly one issued operation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (outPut !== e.res) begin
        n_errors++;
        $display("FAIL %s outPut: got %h expected %h", e.tag, outPut, e.res);
      end
      n_checks++;
      if (isZero !== e.zero) begin
        n_errors++;
        $display("FAIL %s isZero: got %b expected %b", e.tag, isZero, e.zero);
      end
    end
  end

  initial begin
    int op;
    int a;
    int b;
    int pick;
    issue(1'b1, 0, 16'h1234, 16'h1111, "reset");
    issue(1'b1, 4, 16'hFFFF, 16'h0000, "reset_hold");
    issue(1'b0, 0, 1, 1, "add_1_1");
    issue(1'b0, 0, 10, 0, "add_10_0");
    issue(1'b0, 0, 0, 10, "add_0_10");
    issue(1'b0, 0, 10, 10, "add_10_10");
    issue(1'b0, 0, 13, 24, "add_13_24");
    issue(1'b0, 1, 16'hDDDD, 16'h2222, "or_dd_22");
    issue(1'b0, 1, 16'hFFFF, 0, "or_ff_0");
    issue(1'b0, 1, 16'hAAAA, 16'h5555, "or_aa_55");
    issue(1'b0, 1, 8, 0, "or_8_0");
    issue(1'b0, 0, 16'hFFFF, 1, "add_wrap");
    issue(1'b0, 3, 0, 1, "sub_wrap");
    issue(1'b0, 3, 5, 7, "sub_5_7");
    issue(1'b0, 2, 16'hF0F0, 16'h0F0F, "and_zero");
    issue(1'b0, 7, 16'h8000, 1, "slt_neg");
    issue(1'b0, 7, 1, 16'h8000, "slt_pos");
    issue(1'b0, 4, 16'hFFFF, 16'h00FF, "xor");
    issue(1'b0, 5, 16'h0001, 16'h0013, "sll_hi_ignored");
    issue(1'b0, 6, 16'h8000, 15, "srl_15");
    issue(1'b0, 5, 16'hBEEF, 16'hFFF0, "sll_zero_amt");
    issue(1'b0, 6, 16'hBEEF, 16'h0000, "srl_zero_amt");
    issue(1'b0, 0, 1, 1, "add_before_rst");
    issue(1'b1, 0, 1, 1, "mid_reset");
    issue(1'b0, 0, 1, 1, "add_after_rst");
    for (int i = 0; i < 300; i++) begin
      op   = $urandom_range(0, 7);
      pick = $urandom_range(0, 3);
      a    = (pick == 0) ? 16'h8000 : int'($urandom_range(0, 65535));
      b    = (pick == 1) ? 16'hFFFF : int'($urandom_range(0, 65535));
      issue(1'b0, op, a, b, "random");
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected results never checked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_alu_16bit
`default_nettype wire
